// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (I) and data access (D),
// holding the registered winner on the bus until mem_done and routing completion back.
module mem_port_arbiter #(
   parameter int XLEN  = 32,
   parameter int BYTES = XLEN / 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_req,
   input  logic [XLEN-1:0]  i_addr,
   input  logic             i_abort,
   output logic             i_done,
   output logic [XLEN-1:0]  i_rdata,
   input  logic             d_req,
   input  logic             d_we,
   input  logic [XLEN-1:0]  d_addr,
   input  logic [XLEN-1:0]  d_wdata,
   input  logic [BYTES-1:0] d_be,
   output logic             d_done,
   output logic [XLEN-1:0]  d_rdata,
   output logic             mem_rd,
   output logic             mem_wr,
   output logic [XLEN-1:0]  mem_addr,
   output logic [XLEN-1:0]  mem_wdata,
   output logic [BYTES-1:0] mem_be,
   input  logic             mem_done,
   input  logic [XLEN-1:0]  mem_rdata
);

   typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, I_DRAIN} state_t;

   state_t state;
   logic   last_grant_d;
   logic   i_valid;
   logic   grant_window;
   logic   grant_i;
   logic   grant_d;

   // Grants happen from IDLE or on the completion cycle, so a waiting requester
   // follows the finishing one with no idle bubble.
   always_comb begin
      i_valid      = i_req && !i_abort;
      grant_window = (state == IDLE) || mem_done;
      grant_i      = 1'b0;
      grant_d      = 1'b0;
      if (grant_window) begin
         if (i_valid && d_req) begin
            grant_d = !last_grant_d;
            grant_i = last_grant_d;
         end else begin
            grant_i = i_valid;
            grant_d = d_req;
         end
      end
   end

   always_comb begin
      i_done  = (state == I_BUSY) && mem_done && !i_abort;
      d_done  = (state == D_BUSY) && mem_done;
      i_rdata = i_done ? mem_rdata : '0;
      d_rdata = (d_done && !mem_wr) ? mem_rdata : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         last_grant_d <= 1'b0;
         mem_rd       <= 1'b0;
         mem_wr       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         mem_be       <= '0;
      end else if (grant_i) begin
         state        <= I_BUSY;
         last_grant_d <= 1'b0;
         mem_rd       <= 1'b1;
         mem_wr       <= 1'b0;
         mem_addr     <= i_addr;
         mem_wdata    <= '0;
         mem_be       <= '1;
      end else if (grant_d) begin
         state        <= D_BUSY;
         last_grant_d <= 1'b1;
         mem_rd       <= !d_we;
         mem_wr       <= d_we;
         mem_addr     <= d_addr;
         mem_wdata    <= d_wdata;
         mem_be       <= d_be;
      end else if (mem_done && (state != IDLE)) begin
         // Address, data and enables keep their last values when the bus goes idle.
         state  <= IDLE;
         mem_rd <= 1'b0;
         mem_wr <= 1'b0;
      end else if ((state == I_BUSY) && i_abort) begin
         state <= I_DRAIN;
      end
   end

endmodule
